i2s_dsp_rx_deser: RTL and testbench

//  DSP-mode serial receiver that sits downstream of the DSP WS generator. It runs on that generator's sck_i
//  and frame-sync pulse (ws_i), and samples sd_i on posedge sck_i. It deserialises (num_bits+1)-bit words

---
 rtl/i2s_dsp_rx_deser.sv | 223 ++++++++++++++++++++++
 tb/tb_i2s_dsp_rx_deser.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dsp_rx_deser.sv
// rtl/i2s_dsp_rx_deser.sv - DSP-mode serial word receiver with overflow and frame-sync error flags
// Optional feature macro: I2S_DSP_RX_WORD_IDX_EN adds word_idx_o (slot index of the word held in data_o).
module i2s_dsp_rx_deser #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sck_i,
    input  logic                  rst_i,
    input  logic                  cfg_en_i,
    input  logic [4:0]            cfg_num_bits_i,
    input  logic [3:0]            cfg_num_words_i,
    input  logic                  cfg_ws_delay_i,
    input  logic                  cfg_lsb_first_i,
    input  logic                  cfg_clr_i,
    input  logic                  ws_i,
    input  logic                  sd_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic                  overflow_o,
`ifdef I2S_DSP_RX_WORD_IDX_EN
    output logic [3:0]            word_idx_o,
`endif
    output logic                  frame_err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_WS = 2'd1,
        ARM     = 2'd2,
        RECV    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [3:0]            word_cnt_q, word_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  overflow_q, overflow_d;
    logic                  frame_err_q, frame_err_d;
`ifdef I2S_DSP_RX_WORD_IDX_EN
    logic [3:0]            word_idx_q, word_idx_d;
`endif

    // Edge decode: whether this edge samples a bit, which bit/word it is, and sync errors
    logic                  sample;
    logic                  sync_err;
    logic [4:0]            idx;
    logic [3:0]            widx;
    logic                  frame_end_edge;
    logic                  b2b_sync;
    logic                  complete;
    logic                  last_word;
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] word_next;

    // Register update for FSM state and datapath
    always_ff @(posedge sck_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef I2S_DSP_RX_WORD_IDX_EN
            word_idx_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
`ifdef I2S_DSP_RX_WORD_IDX_EN
            word_idx_q  <= word_idx_d;
`endif
        end
    end

    // Classify the current edge; a restart after a sync error behaves like a fresh sync from WAIT_WS
    always_comb begin
        sample         = 1'b0;
        sync_err       = 1'b0;
        idx            = bit_cnt_q;
        widx           = word_cnt_q;
        frame_end_edge = (bit_cnt_q == cfg_num_bits_i) && (word_cnt_q == cfg_num_words_i);
        b2b_sync       = ws_i && cfg_ws_delay_i && frame_end_edge;
        if (cfg_en_i) begin
            case (state_q)
                WAIT_WS: begin
                    if (ws_i && !cfg_ws_delay_i) begin
                        sample = 1'b1;
                        idx    = '0;
                        widx   = '0;
                    end
                end
                ARM: begin
                    if (ws_i) begin
                        sync_err = 1'b1;
                    end else begin
                        sample = 1'b1;
                        idx    = '0;
                        widx   = '0;
                    end
                end
                RECV: begin
                    if (ws_i && !b2b_sync) begin
                        sync_err = 1'b1;
                        if (!cfg_ws_delay_i) begin
                            sample = 1'b1;
                            idx    = '0;
                            widx   = '0;
                        end
                    end else begin
                        sample = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        complete  = sample && (idx == cfg_num_bits_i);
        last_word = (widx == cfg_num_words_i);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!cfg_en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT_WS;
                WAIT_WS: begin
                    if (ws_i) begin
                        if (cfg_ws_delay_i)             state_d = ARM;
                        else if (complete && last_word) state_d = WAIT_WS;
                        else                            state_d = RECV;
                    end
                end
                ARM: begin
                    if (ws_i)                        state_d = ARM;
                    else if (complete && last_word)  state_d = WAIT_WS;
                    else                             state_d = RECV;
                end
                RECV: begin
                    if (sync_err && cfg_ws_delay_i)  state_d = ARM;
                    else if (complete && last_word)  state_d = b2b_sync ? ARM : WAIT_WS;
                    else                             state_d = RECV;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and outputs: shift register, counters, output word handshake, sticky flags
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overflow_d  = cfg_clr_i ? 1'b0 : overflow_q;
        frame_err_d = cfg_clr_i ? 1'b0 : frame_err_q;
`ifdef I2S_DSP_RX_WORD_IDX_EN
        word_idx_d  = word_idx_q;
`endif
        // bit 0 always starts from a clean word so discarded partials never leak in
        base      = (idx == 5'd0) ? '0 : shift_q;
        word_next = base;
        if (cfg_lsb_first_i) begin
            word_next[idx] = sd_i;
        end else begin
            word_next = {base[DATA_WIDTH-2:0], sd_i};
        end

        if (sample) begin
            shift_d = word_next;
            if (complete) begin
                bit_cnt_d  = '0;
                word_cnt_d = last_word ? 4'd0 : widx + 4'd1;
            end else begin
                bit_cnt_d  = idx + 5'd1;
                word_cnt_d = widx;
            end
        end else if (!cfg_en_i || sync_err) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
        end

        if (sync_err) begin
            frame_err_d = 1'b1;
        end

        if (complete) begin
            if (valid_q && !data_ready_i) begin
                overflow_d = 1'b1;
            end else begin
                data_d  = word_next;
                valid_d = 1'b1;
`ifdef I2S_DSP_RX_WORD_IDX_EN
                word_idx_d = widx;
`endif
            end
        end else if (valid_q && data_ready_i) begin
            valid_d = 1'b0;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign overflow_o   = overflow_q;
    assign frame_err_o  = frame_err_q;
`ifdef I2S_DSP_RX_WORD_IDX_EN
    assign word_idx_o   = word_idx_q;
`endif

endmodule

// File: tb/tb_i2s_dsp_rx_deser.sv
// tb/tb_i2s_dsp_rx_deser.sv - directed self-checking bench for i2s_dsp_rx_deser
module tb_i2s_dsp_rx_deser;

    logic        sck_i = 1'b0;
    logic        rst_i;
    logic        cfg_en_i;
    logic [4:0]  cfg_num_bits_i;
    logic [3:0]  cfg_num_words_i;
    logic        cfg_ws_delay_i;
    logic        cfg_lsb_first_i;
    logic        cfg_clr_i;
    logic        ws_i;
    logic        sd_i;
    logic [31:0] data_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic        overflow_o;
    logic        frame_err_o;
`ifdef I2S_DSP_RX_WORD_IDX_EN
    logic [3:0]  word_idx_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 sck_i = ~sck_i;

    i2s_dsp_rx_deser #(.DATA_WIDTH(32)) dut (
        .sck_i           (sck_i),
        .rst_i           (rst_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_num_bits_i  (cfg_num_bits_i),
        .cfg_num_words_i (cfg_num_words_i),
        .cfg_ws_delay_i  (cfg_ws_delay_i),
        .cfg_lsb_first_i (cfg_lsb_first_i),
        .cfg_clr_i       (cfg_clr_i),
        .ws_i            (ws_i),
        .sd_i            (sd_i),
        .data_o          (data_o),
        .data_valid_o    (data_valid_o),
        .data_ready_i    (data_ready_i),
        .overflow_o      (overflow_o),
`ifdef I2S_DSP_RX_WORD_IDX_EN
        .word_idx_o      (word_idx_o),
`endif
        .frame_err_o     (frame_err_o)
    );

    task automatic step();
        @(posedge sck_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int nb, input bit lsb,
                             input bit ws_first, input bit ws_last);
        for (int i = 0; i <= nb; i++) begin
            sd_i = lsb ? w[i] : w[nb - i];
            ws_i = (i == 0 && ws_first) || (i == nb && ws_last);
            step();
        end
        ws_i = 1'b0;
        sd_i = 1'b0;
    endtask

    task automatic configure(input logic [4:0] nb, input logic [3:0] nw, input bit dly, input bit lsb);
        cfg_en_i = 1'b0;
        step();
        cfg_num_bits_i  = nb;
        cfg_num_words_i = nw;
        cfg_ws_delay_i  = dly;
        cfg_lsb_first_i = lsb;
        cfg_en_i        = 1'b1;
        step();
    endtask

    initial begin
        rst_i = 1'b1; cfg_en_i = 1'b0; cfg_num_bits_i = '0; cfg_num_words_i = '0;
        cfg_ws_delay_i = 1'b0; cfg_lsb_first_i = 1'b0; cfg_clr_i = 1'b0;
        ws_i = 1'b0; sd_i = 1'b0; data_ready_i = 1'b1;
        step();
        step();
        check("rst_data", data_o, 32'h0);
        check("rst_valid", {31'b0, data_valid_o}, 32'h0);
        check("rst_ovf", {31'b0, overflow_o}, 32'h0);
        check("rst_ferr", {31'b0, frame_err_o}, 32'h0);
        rst_i = 1'b0;

        // 1: 8b x 2, mode A, MSB-first
        configure(5'd7, 4'd1, 1'b1, 1'b0);
        ws_i = 1'b1; step(); ws_i = 1'b0;
        check("t1_valid_pre", {31'b0, data_valid_o}, 32'h0);
        send_word(32'hA5, 7, 1'b0, 1'b0, 1'b0);
        check("t1_w0_data", data_o, 32'hA5);
        check("t1_w0_valid", {31'b0, data_valid_o}, 32'h1);
        send_word(32'h3C, 7, 1'b0, 1'b0, 1'b0);
        check("t1_w1_data", data_o, 32'h3C);
        check("t1_w1_valid", {31'b0, data_valid_o}, 32'h1);
        check("t1_ovf", {31'b0, overflow_o}, 32'h0);
        check("t1_ferr", {31'b0, frame_err_o}, 32'h0);

        // 2: 16b x 1, mode B, LSB-first, back-to-back frames
        configure(5'd15, 4'd0, 1'b0, 1'b1);
        send_word(32'h1234, 15, 1'b1, 1'b1, 1'b0);
        check("t2_f0_data", data_o, 32'h00001234);
        send_word(32'hBEEF, 15, 1'b1, 1'b1, 1'b0);
        check("t2_f1_data", data_o, 32'h0000BEEF);
        send_word(32'h8001, 15, 1'b1, 1'b1, 1'b0);
        check("t2_f2_data", data_o, 32'h00008001);
        check("t2_valid", {31'b0, data_valid_o}, 32'h1);
        check("t2_ferr", {31'b0, frame_err_o}, 32'h0);

        // 3: 8b x 4, consumer stalled
        configure(5'd7, 4'd3, 1'b0, 1'b0);
        data_ready_i = 1'b0;
        send_word(32'h11, 7, 1'b0, 1'b1, 1'b0);
        check("t3_w0_data", data_o, 32'h11);
        check("t3_w0_ovf", {31'b0, overflow_o}, 32'h0);
        send_word(32'h22, 7, 1'b0, 1'b0, 1'b0);
        check("t3_w1_ovf", {31'b0, overflow_o}, 32'h1);
        send_word(32'h33, 7, 1'b0, 1'b0, 1'b0);
        send_word(32'h44, 7, 1'b0, 1'b0, 1'b0);
        check("t3_held_data", data_o, 32'h11);
        check("t3_held_valid", {31'b0, data_valid_o}, 32'h1);
        cfg_clr_i = 1'b1; step(); cfg_clr_i = 1'b0;
        check("t3_clr_ovf", {31'b0, overflow_o}, 32'h0);
        check("t3_clr_valid", {31'b0, data_valid_o}, 32'h1);
        data_ready_i = 1'b1; step();
        check("t3_accept", {31'b0, data_valid_o}, 32'h0);

        // 4: 8b x 2, sync pulse in the middle of word 1
        configure(5'd7, 4'd1, 1'b0, 1'b0);
        send_word(32'h77, 7, 1'b0, 1'b1, 1'b0);
        check("t4_w0_data", data_o, 32'h77);
        check("t4_ferr_pre", {31'b0, frame_err_o}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            sd_i = 1'b1; ws_i = 1'b0; step();
        end
        send_word(32'h5A, 7, 1'b0, 1'b1, 1'b0);
        check("t4_restart_data", data_o, 32'h5A);
        check("t4_ferr", {31'b0, frame_err_o}, 32'h1);
`ifdef I2S_DSP_RX_WORD_IDX_EN
        check("t4_idx", {28'b0, word_idx_o}, 32'h0);
`endif
        cfg_en_i = 1'b0; step();
        cfg_clr_i = 1'b1; step(); cfg_clr_i = 1'b0;
        check("t4_clr_ferr", {31'b0, frame_err_o}, 32'h0);

        // 5: enable drop mid-word, then reset mid-frame
        configure(5'd7, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            sd_i = 1'b1; ws_i = (i == 0); step();
        end
        ws_i = 1'b0; sd_i = 1'b0;
        cfg_en_i = 1'b0; step();
        check("t5_drop_valid", {31'b0, data_valid_o}, 32'h0);
        check("t5_drop_data", data_o, 32'h5A);
        cfg_en_i = 1'b1; step();
        send_word(32'h96, 7, 1'b1, 1'b1, 1'b0);
        check("t5_new_data", data_o, 32'h96);
        check("t5_new_ferr", {31'b0, frame_err_o}, 32'h0);
        send_word(32'h0F, 7, 1'b1, 1'b1, 1'b0);
        check("t5_new2_data", data_o, 32'h0F);
        for (int i = 0; i < 3; i++) begin
            sd_i = 1'b1; ws_i = (i == 0); step();
        end
        ws_i = 1'b0;
        rst_i = 1'b1; step(); rst_i = 1'b0;
        check("t5_rst_data", data_o, 32'h0);
        check("t5_rst_valid", {31'b0, data_valid_o}, 32'h0);
        check("t5_rst_ovf", {31'b0, overflow_o}, 32'h0);
        check("t5_rst_ferr", {31'b0, frame_err_o}, 32'h0);

        // 6: 32b x 16, mode A, back-to-back sync on the last bit, wrap to word 0
        configure(5'd31, 4'd15, 1'b1, 1'b0);
        ws_i = 1'b1; step(); ws_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            send_word(32'(k), 31, 1'b0, 1'b0, (k == 15));
            check($sformatf("t6_w%0d_data", k), data_o, 32'(k));
            check($sformatf("t6_w%0d_valid", k), {31'b0, data_valid_o}, 32'h1);
`ifdef I2S_DSP_RX_WORD_IDX_EN
            check($sformatf("t6_w%0d_idx", k), {28'b0, word_idx_o}, 32'(k));
`endif
        end
        send_word(32'hCAFEF00D, 31, 1'b0, 1'b0, 1'b0);
        check("t6_wrap_data", data_o, 32'hCAFEF00D);
`ifdef I2S_DSP_RX_WORD_IDX_EN
        check("t6_wrap_idx", {28'b0, word_idx_o}, 32'h0);
`endif
        check("t6_ferr", {31'b0, frame_err_o}, 32'h0);
        check("t6_ovf", {31'b0, overflow_o}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
